gerador_de_pulsos: RTL and testbench
====================================

# gerador_de_pulsos

Stimulus-side counterpart of `detector_de_pulso`: it generates single-cycle pulse trains on `a` and `b`, which the detector then classifies.

- A command gives the number of pulses for each line (`n_a`, `n_b`) and the idle gap between pulses.
- Pulses on `a` and `b` are emitted together, slot by slot, until both counts are exhausted, then `done` is flagged.
- It drives `detector_de_pulso` in integration benches and on-chip self-test, replacing random stimulus with reproducible sequences.

## Interface

Parameters:
- `CNT_W`, default 4: width of the pulse-count inputs (0 to 2^CNT_W−1 pulses per line).
- `GAP_W`, default 4: width of the gap input.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: synchronous, active-high.
- `start`, in, 1: command request; sampled only when `ready`=1.
- `n_a`, in, CNT_W: number of pulses on `a`.
- `n_b`, in, CNT_W: number of pulses on `b`.
- `gap`, in, GAP_W: low cycles between pulse slots; 0 is treated as 1.
- `ready`, out, 1: idle, command accepted this edge if `start`=1.
- `busy`, out, 1: command in progress.
- `a`, out, 1: pulse output A, registered.
- `b`, out, 1: pulse output B, registered.
- `done`, out, 1: one-cycle completion strobe, registered.

## Operation

FSM states: IDLE, PULSE, GAP, DONE.
- **IDLE**:
  - `ready`=1, `busy`=0, `a`=`b`=0.
  - On `start`, latch `n_a`, `n_b` and g = max(`gap`,1).
  - If `n_a`=`n_b`=0, go to DONE. Otherwise go to PULSE.
- **PULSE** (one cycle):
  - `a`=1 iff remaining A count > 0; `b`=1 iff remaining B count > 0. Simultaneous pulses are allowed.
  - Both nonzero counts decrement.
  - If both counts are now zero, go to DONE; otherwise go to GAP with the gap counter loaded to g.
- **GAP**:
  - `a`=`b`=0 for exactly g cycles, then PULSE.
- **DONE** (one cycle):
  - `done`=1, `a`=`b`=0, `busy`=1, then IDLE.
- **Pulse count and spacing**:
  - Total pulse slots P = max(`n_a`,`n_b`).
  - Slot period is 1+g cycles.
  - The shorter line simply stops pulsing early; there is no trailing gap after the last slot.
- **Ignored inputs**: `start` while `busy`=1 is ignored, and inputs are not re-latched.
- **Reset**:
  - Takes effect at the next edge, from any state, including mid-command.
  - Returns to IDLE with `a`=`b`=`done`=`busy`=0 and `ready`=1.
  - An aborted command produces no `done`.
  - `start` is ignored while `reset`=1.
- **Counter arithmetic**: unsigned, never wraps. Decrement saturates at 0; the gap counter counts g−1 down to 0.

## Timing

- Accepting edge = edge E0, where `start`=1 and `ready`=1.
- Slot k (k = 0..P−1) is driven in the cycle after edge E0 + k·(1+g). The first pulse therefore appears in the cycle immediately after the accepting edge.
- `done` is high in the cycle following the last pulse slot. For P=0, `done` is high in the cycle right after E0.
- `ready` returns in the cycle after `done`, so back-to-back commands leave at least 2 low cycles between trains.
- `ready` and `busy` are decoded from the state register. All other outputs are registered; there is no combinational path from inputs to `a`, `b` or `done`.

## Structure

- **`pulsos_pkg`**: state enum (IDLE, PULSE, GAP, DONE) and default CNT_W/GAP_W constants. `detector_de_pulso` benches import the same package.
- **`contador_descendente`** sub-module: loadable down-counter with `load`, `value`, `dec` and `zero` signals, and a width parameter. It is instantiated for the A count, the B count and the gap.

## Test plan

- `n_a`=3, `n_b`=1, `gap`=2 → `a` high in cycles 0, 3, 6; `b` high in cycle 0; `done` in cycle 7; `ready` in cycle 8.
- `n_a`=2, `n_b`=2, `gap`=0 → gap treated as 1; `a` and `b` both high in cycles 0 and 2; `done` in cycle 3.
- `n_a`=0, `n_b`=0 → no pulses; `done` in cycle 0; `ready` in cycle 1.
- Command `n_a`=3, `gap`=2; reassert `start` with `n_a`=7 at cycle 2 → ignored, only 3 pulses; then a second command accepted on the `ready` edge → first pulse 2 cycles after the previous `done`.
- Reset asserted during cycle 4 of the first scenario → `a`=`b`=`busy`=0 and `ready`=1 from the next cycle; no `done`, no further pulses.
- `n_a`=15, `n_b`=0, `gap`=15 → 15 `a` pulses at cycles 0, 16, …, 224; `b` stays low; `done` in cycle 225.

Source files
------------

// File: rtl/pulsos_pkg.sv
// pulsos_pkg
//   Shared definitions for the pulse generator and the pulse detector benches:
//   FSM state encoding and default counter widths.
package pulsos_pkg;

    localparam int unsigned DEF_CNT_W = 4;
    localparam int unsigned DEF_GAP_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        GAP,
        DONE
    } state_t;

endpackage

// File: rtl/gerador_de_pulsos_contador.sv
// contador_descendente
//   Loadable down-counter that saturates at zero.
//   Ports:
//     clk, reset  - clock and synchronous active-high reset (clears count)
//     load_i      - load value_i into the counter (has priority over dec_i)
//     value_i     - load value
//     dec_i       - decrement by one, holding at zero
//     count_o     - current count
//     zero_o      - count is zero
module contador_descendente #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] value_i,
    input  logic         dec_i,
    output logic [W-1:0] count_o,
    output logic         zero_o
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= value_i;
        end else if (dec_i && (count_q != '0)) begin
            count_q <= count_q - W'(1);
        end
    end

    assign count_o = count_q;
    assign zero_o  = (count_q == '0);

endmodule

// File: rtl/gerador_de_pulsos.sv
// gerador_de_pulsos
//   Generates reproducible single-cycle pulse trains on a and b. A command
//   sets the pulse count per line and the idle gap between pulse slots;
//   both lines pulse together slot by slot until both counts run out.
//   Ports:
//     clk, reset  - clock and synchronous active-high reset
//     start       - command request, taken only while ready
//     n_a, n_b    - pulses to emit on a / b
//     gap         - low cycles between slots (0 behaves as 1)
//     ready       - idle; a start on this edge is accepted
//     busy        - command in progress
//     a, b        - registered pulse outputs
//     done        - registered one-cycle completion strobe
module gerador_de_pulsos
    import pulsos_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W,
    parameter int unsigned GAP_W = DEF_GAP_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] n_a,
    input  logic [CNT_W-1:0] n_b,
    input  logic [GAP_W-1:0] gap,
    output logic             ready,
    output logic             busy,
    output logic             a,
    output logic             b,
    output logic             done
);

    state_t state_q, state_d;

    logic [GAP_W-1:0] g_q;
    logic             a_q, a_d;
    logic             b_q, b_d;
    logic             done_q, done_d;

    logic             accept;
    logic [CNT_W-1:0] cnt_a, cnt_b;
    logic             zero_a, zero_b;
    logic [GAP_W-1:0] cnt_gap;
    logic             zero_gap;

    assign accept = (state_q == IDLE) && start;

    contador_descendente #(.W(CNT_W)) u_cnt_a (
        .clk     (clk),
        .reset   (reset),
        .load_i  (accept),
        .value_i (n_a),
        .dec_i   (state_q == PULSE),
        .count_o (cnt_a),
        .zero_o  (zero_a)
    );

    contador_descendente #(.W(CNT_W)) u_cnt_b (
        .clk     (clk),
        .reset   (reset),
        .load_i  (accept),
        .value_i (n_b),
        .dec_i   (state_q == PULSE),
        .count_o (cnt_b),
        .zero_o  (zero_b)
    );

    // Loaded with g-1 during each pulse so GAP lasts exactly g cycles.
    contador_descendente #(.W(GAP_W)) u_cnt_gap (
        .clk     (clk),
        .reset   (reset),
        .load_i  (state_q == PULSE),
        .value_i (g_q - GAP_W'(1)),
        .dec_i   (state_q == GAP),
        .count_o (cnt_gap),
        .zero_o  (zero_gap)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ((n_a == '0) && (n_b == '0)) ? DONE : PULSE;
                end
            end
            PULSE: begin
                // Counts reach zero after this slot's decrement.
                if ((cnt_a <= CNT_W'(1)) && (cnt_b <= CNT_W'(1))) begin
                    state_d = DONE;
                end else begin
                    state_d = GAP;
                end
            end
            GAP: begin
                if (zero_gap) begin
                    state_d = PULSE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state. PULSE is only ever entered
    // from IDLE (counts arrive on the inputs this edge) or from GAP (counts
    // already in the counters and unchanged), never from PULSE itself.
    always_comb begin
        a_d    = 1'b0;
        b_d    = 1'b0;
        done_d = (state_d == DONE);
        if (state_d == PULSE) begin
            if (state_q == IDLE) begin
                a_d = (n_a != '0);
                b_d = (n_b != '0);
            end else begin
                a_d = !zero_a;
                b_d = !zero_b;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            g_q     <= GAP_W'(1);
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            done_q  <= done_d;
            if (accept) begin
                g_q <= (gap == '0) ? GAP_W'(1) : gap;
            end
        end
    end

    assign ready = (state_q == IDLE);
    assign busy  = (state_q != IDLE);
    assign a     = a_q;
    assign b     = b_q;
    assign done  = done_q;

endmodule

// File: tb/tb_gerador_de_pulsos.sv
// tb_gerador_de_pulsos
//   Self-checking bench for gerador_de_pulsos. Each command pushes the
//   expected per-cycle {a,b,done,ready,busy} vector, derived from the slot
//   timing formulas, into a queue; each test pops and compares per cycle.
module tb_gerador_de_pulsos;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] n_a, n_b, gap;
    logic       ready, busy, a, b, done;

    int n_tests = 0;
    int n_fail  = 0;

    logic [4:0] sb[$];

    gerador_de_pulsos #(.CNT_W(4), .GAP_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .n_a   (n_a),
        .n_b   (n_b),
        .gap   (gap),
        .ready (ready),
        .busy  (busy),
        .a     (a),
        .b     (b),
        .done  (done)
    );

    always #5 clk = ~clk;

    // Drives a command (accepted on the coming edge) and queues expected
    // vectors for cycle 0 (after the accepting edge) through the ready cycle.
    task automatic issue(input int na, input int nb, input int gp);
        int g, p, done_c;
        logic ea, eb;
        g = (gp == 0) ? 1 : gp;
        p = (na > nb) ? na : nb;
        done_c = (p == 0) ? 0 : (p - 1) * (g + 1) + 1;
        for (int c = 0; c <= done_c + 1; c++) begin
            ea = ((c % (g + 1)) == 0) && ((c / (g + 1)) < na);
            eb = ((c % (g + 1)) == 0) && ((c / (g + 1)) < nb);
            sb.push_back({ea, eb, c == done_c, c == done_c + 1, c <= done_c});
        end
        n_a   = 4'(na);
        n_b   = 4'(nb);
        gap   = 4'(gp);
        start = 1'b1;
    endtask

    task automatic test_reset();
        logic [4:0] obs;
        reset = 1'b1;
        start = 1'b1;
        n_a = 4'd5; n_b = 4'd5; gap = 4'd1;
        repeat (2) @(posedge clk);
        #1;
        obs = {a, b, done, ready, busy};
        n_tests++;
        if (obs !== 5'b00010) begin
            n_fail++;
            $display("FAIL reset_state: got %b expected %b", obs, 5'b00010);
        end
        start = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
        obs = {a, b, done, ready, busy};
        n_tests++;
        if (obs !== 5'b00010) begin
            n_fail++;
            $display("FAIL reset_release: got %b expected %b", obs, 5'b00010);
        end
    endtask

    task automatic test_basic(input string name, input int na, input int nb, input int gp);
        logic [4:0] obs, exp;
        int idx = 0;
        issue(na, nb, gp);
        while (sb.size() != 0) begin
            @(posedge clk); #1;
            start = 1'b0;
            exp = sb.pop_front();
            obs = {a, b, done, ready, busy};
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL %s cycle %0d: got %b expected %b", name, idx, obs, exp);
            end
            idx++;
        end
    endtask

    task automatic test_ignored_start_back_to_back();
        logic [4:0] obs, exp;
        int idx = 0;
        bit second = 0;
        issue(3, 0, 2);
        while (sb.size() != 0) begin
            @(posedge clk); #1;
            start = 1'b0;
            exp = sb.pop_front();
            obs = {a, b, done, ready, busy};
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL b2b cycle %0d: got %b expected %b", idx, obs, exp);
            end
            if (!second && idx == 2) begin
                n_a = 4'd7; n_b = 4'd7; gap = 4'd0;
                start = 1'b1;
            end
            if (!second && sb.size() == 0) begin
                second = 1;
                issue(2, 1, 1);
            end
            idx++;
        end
    endtask

    task automatic test_reset_mid();
        logic [4:0] obs, exp;
        int idx = 0;
        issue(3, 1, 2);
        while (idx <= 4) begin
            @(posedge clk); #1;
            start = 1'b0;
            exp = sb.pop_front();
            obs = {a, b, done, ready, busy};
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL reset_mid cycle %0d: got %b expected %b", idx, obs, exp);
            end
            idx++;
        end
        sb.delete();
        reset = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        start = 1'b0;
        for (int c = 0; c < 12; c++) begin
            obs = {a, b, done, ready, busy};
            n_tests++;
            if (obs !== 5'b00010) begin
                n_fail++;
                $display("FAIL reset_abort cycle %0d: got %b expected %b", c, obs, 5'b00010);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        n_a = '0; n_b = '0; gap = '0;
        test_reset();
        test_basic("n3_1_g2", 3, 1, 2);
        test_basic("n2_2_g0", 2, 2, 0);
        test_basic("n0_0", 0, 0, 5);
        test_basic("n1_4_g3", 1, 4, 3);
        test_ignored_start_back_to_back();
        test_reset_mid();
        test_basic("n15_0_g15", 15, 0, 15);
        for (int r = 0; r < 6; r++) begin
            test_basic("random", int'($urandom_range(0, 6)), int'($urandom_range(0, 6)),
                       int'($urandom_range(0, 4)));
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
